// File: rtl/secuenciador_cafe.sv
// secuenciador_cafe: brew-sequencing FSM that sits in front of the `temporizador` timer.
// It turns a start press and a recipe select into timed stages: heat, coffee, then optional milk.
// For each stage it loads `value`, pulses `start_timer` once, and waits for a rising `t_expired`.
// Optional build macro CUP_COUNTER_EN adds an 8-bit saturating count of completed brews on `tazas`.
// Handshake with the timer: `value` is valid and stable whenever `start_timer` is high and stays
// stable for the whole stage; only a rising edge of `t_expired` completes the stage, and an edge
// that coincides with `start_timer` belongs to the previous run and is discarded.
// The current state is visible on `estado_o` for debug.
module secuenciador_cafe #(
   parameter int unsigned DONE_HOLD = 8
) (
   input  logic       clk_100MHz,
   input  logic       rst,
   input  logic       boton,
   input  logic [1:0] tipo,
   input  logic       agua_ok,
   input  logic       taza_ok,
   input  logic       t_expired,
   output logic [1:0] value,
   output logic       start_timer,
   output logic       heater,
   output logic       pump,
   output logic       milk,
   output logic       busy,
   output logic       done,
   output logic       error,
`ifdef CUP_COUNTER_EN
   output logic [7:0] tazas,
`endif
   output logic [2:0] estado_o
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HEAT   = 3'd1,
      COFFEE = 3'd2,
      MILK   = 3'd3,
      DONE   = 3'd4,
      ERROR  = 3'd5
   } estado_t;

   localparam int HW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(DONE_HOLD - 1);

   estado_t       state_q, state_d;
   logic [1:0]    tipo_q, tipo_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          boton_q, texp_q;
   logic          boton_ev, exp_ev, stage_exp, sensors_ok;
   logic [1:0]    tipo_eff;

   logic [1:0]    value_q, value_d;
   logic          start_q, start_d;
   logic          heater_q, pump_q, milk_q, busy_q, done_q, error_q;

   // Recipe durations.
   function automatic logic [1:0] dur_heat(input logic [1:0] t);
      return t[1] ? 2'd2 : 2'd3;
   endfunction

   function automatic logic [1:0] dur_coffee(input logic [1:0] t);
      case (t)
         2'd0:    return 2'd2;
         2'd1:    return 2'd3;
         2'd2:    return 2'd2;
         default: return 2'd1;
      endcase
   endfunction

   function automatic logic [1:0] dur_milk(input logic [1:0] t);
      case (t)
         2'd2:    return 2'd3;
         2'd3:    return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   assign boton_ev   = boton & ~boton_q;
   assign exp_ev     = t_expired & ~texp_q;
   assign stage_exp  = exp_ev & ~start_q;
   assign sensors_ok = agua_ok & taza_ok;
   // While idle the recipe comes straight from the select so HEAT entry can load its duration.
   assign tipo_eff   = (state_q == IDLE) ? tipo : tipo_q;

   // Next-state, recipe latch and hold counter.
   always_comb begin
      state_d = state_q;
      tipo_d  = tipo_q;
      hold_d  = (state_q == DONE) ? hold_q + 1'b1 : '0;
      case (state_q)
         IDLE: begin
            if (boton_ev) begin
               if (sensors_ok) begin
                  state_d = HEAT;
                  tipo_d  = tipo;
               end else begin
                  state_d = ERROR;
               end
            end
         end
         HEAT: begin
            if (!sensors_ok)    state_d = ERROR;
            else if (stage_exp) state_d = COFFEE;
         end
         COFFEE: begin
            if (!sensors_ok)    state_d = ERROR;
            else if (stage_exp) state_d = (dur_milk(tipo_q) != 2'd0) ? MILK : DONE;
         end
         MILK: begin
            if (!sensors_ok)    state_d = ERROR;
            else if (stage_exp) state_d = DONE;
         end
         DONE: begin
            if (hold_q == HOLD_LAST) state_d = IDLE;
         end
         ERROR: begin
            if (boton_ev) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs are computed from the next state so they line up with the state register.
   always_comb begin
      value_d = 2'd0;
      start_d = 1'b0;
      case (state_d)
         HEAT:    value_d = dur_heat(tipo_eff);
         COFFEE:  value_d = dur_coffee(tipo_eff);
         MILK:    value_d = dur_milk(tipo_eff);
         default: value_d = 2'd0;
      endcase
      if ((state_d == HEAT || state_d == COFFEE || state_d == MILK) && (state_d != state_q))
         start_d = 1'b1;
   end

   // State, edge-detect and output registers.
   always_ff @(posedge clk_100MHz) begin
      if (rst) begin
         state_q  <= IDLE;
         tipo_q   <= 2'd0;
         hold_q   <= '0;
         boton_q  <= 1'b0;
         texp_q   <= 1'b0;
         value_q  <= 2'd0;
         start_q  <= 1'b0;
         heater_q <= 1'b0;
         pump_q   <= 1'b0;
         milk_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         tipo_q   <= tipo_d;
         hold_q   <= hold_d;
         boton_q  <= boton;
         texp_q   <= t_expired;
         value_q  <= value_d;
         start_q  <= start_d;
         heater_q <= (state_d == HEAT);
         pump_q   <= (state_d == COFFEE);
         milk_q   <= (state_d == MILK);
         busy_q   <= (state_d == HEAT) || (state_d == COFFEE) || (state_d == MILK);
         done_q   <= (state_d == DONE);
         error_q  <= (state_d == ERROR);
      end
   end

`ifdef CUP_COUNTER_EN
   logic [7:0] tazas_q;

   // Completed brews only: a stage leaving for DONE, saturating at 255.
   always_ff @(posedge clk_100MHz) begin
      if (rst) begin
         tazas_q <= 8'd0;
      end else if ((state_q == COFFEE || state_q == MILK) && state_d == DONE &&
                   tazas_q != 8'hFF) begin
         tazas_q <= tazas_q + 8'd1;
      end
   end

   assign tazas = tazas_q;
`endif

   assign value       = value_q;
   assign start_timer = start_q;
   assign heater      = heater_q;
   assign pump        = pump_q;
   assign milk        = milk_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign estado_o    = state_q;

endmodule

// File: tb/tb_secuenciador_cafe.sv
// Directed bench for secuenciador_cafe. Inputs change 1 time unit after each rising edge
// and outputs are compared at that same point, well clear of the next edge.
module tb_secuenciador_cafe;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_HEAT   = 3'd1;
   localparam logic [2:0] S_COFFEE = 3'd2;
   localparam logic [2:0] S_MILK   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
   localparam logic [2:0] S_ERROR  = 3'd5;

   logic       clk_100MHz = 1'b0;
   logic       rst, boton, agua_ok, taza_ok, t_expired;
   logic [1:0] tipo;
   logic [1:0] value;
   logic       start_timer, heater, pump, milk, busy, done, error;
   logic [2:0] estado_o;
`ifdef CUP_COUNTER_EN
   logic [7:0] tazas;
`endif

   int vectors = 0;
   int miscompares = 0;

   secuenciador_cafe #(.DONE_HOLD(8)) dut (
      .clk_100MHz (clk_100MHz),
      .rst        (rst),
      .boton      (boton),
      .tipo       (tipo),
      .agua_ok    (agua_ok),
      .taza_ok    (taza_ok),
      .t_expired  (t_expired),
      .value      (value),
      .start_timer(start_timer),
      .heater     (heater),
      .pump       (pump),
      .milk       (milk),
      .busy       (busy),
      .done       (done),
      .error      (error),
`ifdef CUP_COUNTER_EN
      .tazas      (tazas),
`endif
      .estado_o   (estado_o)
   );

   // Clock.
   always #5 clk_100MHz = ~clk_100MHz;

   task automatic step();
      @(posedge clk_100MHz);
      #1;
   endtask

   // Expected output word: {state, start, value, heater, pump, milk, busy, done, error}.
   function automatic logic [12:0] ev(input logic [2:0] st, input logic s, input logic [1:0] v,
                                      input logic h, input logic p, input logic m,
                                      input logic b, input logic d, input logic e);
      return {st, s, v, h, p, m, b, d, e};
   endfunction

   task automatic chk(input string tag, input logic [12:0] exp);
      logic [12:0] got;
      got = {estado_o, start_timer, value, heater, pump, milk, busy, done, error};
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %b expected %b (state,start,value,htr,pump,milk,busy,done,err)",
                tag, got, exp);
      end
   endtask

`ifdef CUP_COUNTER_EN
   task automatic chk_tazas(input string tag, input logic [7:0] exp);
      vectors++;
      assert (tazas === exp) else begin
         miscompares++;
         $error("FAIL %s: tazas got %0d expected %0d", tag, tazas, exp);
      end
   endtask

   task automatic brew_espresso();
      tipo = 2'd0; boton = 1'b1; step();
      boton = 1'b0; step();
      t_expired = 1'b1; step();
      t_expired = 1'b0; step();
      t_expired = 1'b1; step();
      t_expired = 1'b0;
      repeat (9) step();
   endtask
`endif

   initial begin
      rst = 1'b1; boton = 1'b0; tipo = 2'd0; agua_ok = 1'b1; taza_ok = 1'b1; t_expired = 1'b0;
      step(); step();
      rst = 1'b0;
      chk("reset_state", ev(S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 0));

      // Reset in the middle of COFFEE (americano).
      tipo = 2'd1; boton = 1'b1; step();
      chk("rst_heat_entry", ev(S_HEAT, 1, 2'd3, 1, 0, 0, 1, 0, 0));
      boton = 1'b0; t_expired = 1'b1; step();
      t_expired = 1'b0; step();
      t_expired = 1'b1; step();
      chk("rst_coffee_entry", ev(S_COFFEE, 1, 2'd3, 0, 1, 0, 1, 0, 0));
      t_expired = 1'b0; step();
      chk("rst_coffee_hold", ev(S_COFFEE, 0, 2'd3, 0, 1, 0, 1, 0, 0));
      rst = 1'b1; step();
      chk("rst_mid_brew", ev(S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 0));
      rst = 1'b0; step();
      chk("rst_release", ev(S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 0));

      // Latte: 2, 2, 3; tipo changes after the press must be ignored.
      tipo = 2'd2; boton = 1'b1; step();
      chk("latte_heat_start", ev(S_HEAT, 1, 2'd2, 1, 0, 0, 1, 0, 0));
      boton = 1'b0; tipo = 2'd1; step();
      chk("latte_heat_hold", ev(S_HEAT, 0, 2'd2, 1, 0, 0, 1, 0, 0));
      t_expired = 1'b1; step();
      chk("latte_coffee_start", ev(S_COFFEE, 1, 2'd2, 0, 1, 0, 1, 0, 0));
      t_expired = 1'b0; step();
      chk("latte_coffee_hold", ev(S_COFFEE, 0, 2'd2, 0, 1, 0, 1, 0, 0));
      t_expired = 1'b1; step();
      chk("latte_milk_start", ev(S_MILK, 1, 2'd3, 0, 0, 1, 1, 0, 0));
      t_expired = 1'b0; step();
      chk("latte_milk_hold", ev(S_MILK, 0, 2'd3, 0, 0, 1, 1, 0, 0));
      t_expired = 1'b1; step();
      chk("latte_done_1", ev(S_DONE, 0, 2'd0, 0, 0, 0, 0, 1, 0));
      t_expired = 1'b0;
      for (int i = 2; i <= 8; i++) begin
         if (i == 4) boton = 1'b1;   // press during DONE is ignored
         step();
         chk("latte_done_hold", ev(S_DONE, 0, 2'd0, 0, 0, 0, 0, 1, 0));
      end
      step();
      chk("latte_back_idle", ev(S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 0));
      step();
      chk("latte_level_ignored", ev(S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 0));
      boton = 1'b0; step();

      // Espresso: 3, 2, no milk; expiry coincident with start and held levels are ignored.
      tipo = 2'd0; boton = 1'b1; step();
      chk("esp_heat_start", ev(S_HEAT, 1, 2'd3, 1, 0, 0, 1, 0, 0));
      boton = 1'b0; t_expired = 1'b1; step();
      chk("esp_exp_on_start", ev(S_HEAT, 0, 2'd3, 1, 0, 0, 1, 0, 0));
      step();
      chk("esp_exp_level", ev(S_HEAT, 0, 2'd3, 1, 0, 0, 1, 0, 0));
      t_expired = 1'b0; step();
      t_expired = 1'b1; step();
      chk("esp_coffee_start", ev(S_COFFEE, 1, 2'd2, 0, 1, 0, 1, 0, 0));
      step();
      chk("esp_coffee_level", ev(S_COFFEE, 0, 2'd2, 0, 1, 0, 1, 0, 0));
      t_expired = 1'b0; step();
      t_expired = 1'b1; step();
      chk("esp_skip_milk", ev(S_DONE, 0, 2'd0, 0, 0, 0, 0, 1, 0));
      t_expired = 1'b0;
      repeat (8) step();
      chk("esp_back_idle", ev(S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 0));
`ifdef CUP_COUNTER_EN
      chk_tazas("tazas_two", 8'd2);
`endif

      // Abort in COFFEE (capuchino) by removing the cup, then acknowledge.
      tipo = 2'd3; boton = 1'b1; step();
      chk("abort_heat_start", ev(S_HEAT, 1, 2'd2, 1, 0, 0, 1, 0, 0));
      boton = 1'b0; step();
      t_expired = 1'b1; step();
      chk("abort_coffee_start", ev(S_COFFEE, 1, 2'd1, 0, 1, 0, 1, 0, 0));
      t_expired = 1'b0; taza_ok = 1'b0; step();
      chk("abort_error", ev(S_ERROR, 0, 2'd0, 0, 0, 0, 0, 0, 1));
      taza_ok = 1'b1; step();
      chk("abort_error_hold", ev(S_ERROR, 0, 2'd0, 0, 0, 0, 0, 0, 1));
      boton = 1'b1; step();
      chk("abort_ack", ev(S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 0));
      step();
      chk("abort_no_restart", ev(S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 0));
      boton = 1'b0; step();

      // Water drops together with an expiry edge in HEAT: abort wins.
      tipo = 2'd1; boton = 1'b1; step();
      chk("prio_heat_start", ev(S_HEAT, 1, 2'd3, 1, 0, 0, 1, 0, 0));
      boton = 1'b0; step();
      agua_ok = 1'b0; t_expired = 1'b1; step();
      chk("prio_error", ev(S_ERROR, 0, 2'd0, 0, 0, 0, 0, 0, 1));
      agua_ok = 1'b1; t_expired = 1'b0; step();
      chk("prio_no_start", ev(S_ERROR, 0, 2'd0, 0, 0, 0, 0, 0, 1));
      boton = 1'b1; step();
      chk("prio_ack", ev(S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 0));
      boton = 1'b0; step();

      // Press with no cup goes straight to ERROR.
      taza_ok = 1'b0; boton = 1'b1; step();
      chk("nocup_error", ev(S_ERROR, 0, 2'd0, 0, 0, 0, 0, 0, 1));
      boton = 1'b0; taza_ok = 1'b1; step();
      boton = 1'b1; step();
      chk("nocup_ack", ev(S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 0));
      boton = 1'b0; step();

`ifdef CUP_COUNTER_EN
      chk_tazas("tazas_aborts_ignored", 8'd2);
      for (int n = 0; n < 253; n++) brew_espresso();
      chk_tazas("tazas_255", 8'd255);
      brew_espresso();
      chk_tazas("tazas_saturate", 8'd255);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
